cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Two-master, one-slave arbiter that shares the single SRAM-like memory port between the instruction cache and the data cache (write-back, write-allocate, one word per transfer). It sits between both cache controllers and the AXI bridge. It grants one transaction at a time, holds the grant until that transaction's `data_ok`, and routes handshakes only to the owning master.

## Interface
Parameters:
- `A_WIDTH`, 32, address width of all three ports.

Ports:
- `clk`  in  1  system clock; everything samples on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `inst_req` / `inst_wr`  in  1 / 1  I-cache request and write flag.
- `inst_wen` / `inst_size`  in  4 / 2  I-cache byte enables and transfer size.
- `inst_addr` / `inst_wdata`  in  A_WIDTH / 32  I-cache address and write data.
- `inst_rdata`  out  32  read data to the I-cache.
- `inst_addr_ok` / `inst_data_ok`  out  1 / 1  handshakes to the I-cache.
- `data_req` / `data_wr` / `data_wen` / `data_size` / `data_addr` / `data_wdata`  in  1 / 1 / 4 / 2 / A_WIDTH / 32  D-cache request fields.
- `data_rdata` / `data_addr_ok` / `data_data_ok`  out  32 / 1 / 1  D-cache returns.
- `mem_req` / `mem_wr` / `mem_wen` / `mem_size` / `mem_addr` / `mem_wdata`  out  1 / 1 / 4 / 2 / A_WIDTH / 32  memory-side request fields.
- `mem_rdata` / `mem_addr_ok` / `mem_data_ok`  in  32 / 1 / 1  memory-side returns.
- `owner`  out  2  one-hot current grant: bit0 = inst, bit1 = data; 2'b00 when idle.

## Operation
- State machine (registered):
  - IDLE → ADDR when any master has `req` high; the winner is latched into `owner`.
  - ADDR → DATA on `mem_addr_ok`.
  - ADDR → IDLE on `mem_addr_ok & mem_data_ok` in the same cycle.
  - ADDR → IDLE if the owner's `req` drops before `addr_ok` (request abandoned; nothing is forwarded).
  - DATA → IDLE on `mem_data_ok`.
- Arbitration happens only in IDLE. Default policy is fixed priority: data beats inst.
- Request mux:
  - In ADDR, every `mem_*` request field equals the owner's field, and `mem_req` = owner's `req`.
  - In IDLE and DATA, `mem_req` = 0 and the other `mem_*` outputs are 0.
- Returns:
  - `mem_rdata` is broadcast to both `*_rdata` unmodified.
  - `mem_addr_ok` is forwarded combinationally to the owner only, and only in ADDR.
  - `mem_data_ok` is forwarded combinationally to the owner only, in DATA (or in ADDR on the coincident case).
  - A non-owner never sees `addr_ok` or `data_ok`.
- Spurious `mem_data_ok` in IDLE is dropped.
- Reset values: state IDLE, `owner` = 0, `mem_req` = 0, all `mem_*` = 0, all `*_addr_ok` = 0, all `*_data_ok` = 0.

## Timing
- Arbitration latency: request first high in IDLE at cycle N gives `mem_req` = 1 at N+1.
- `addr_ok` at cycle M reaches the owner at M; the state is DATA at M+1.
- `data_ok` at cycle K reaches the owner at K (zero latency); the state is IDLE at K+1; the earliest next `mem_req` is K+2.
- One transaction outstanding at most; no pipelining of the address phase.
- Reset asserted mid-transaction clears state and outputs immediately (asynchronous). A late `mem_data_ok` after reset release lands in IDLE and is dropped.
- Both requests arrive in the same cycle: resolved by the policy; the loser stays pending until the next IDLE.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Adds a `last_grant` register, reset to inst.
  - On a tie, the master not in `last_grant` wins; a lone requester always wins.
  - `last_grant` updates on each IDLE→ADDR transition.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, data always wins ties; no `last_grant` register.

## Test plan
- Lone I-cache read, `addr` 0x1FC0_0000, slave `addr_ok` at +2, `data_ok` at +4 with 0xDEAD_BEEF → `inst_data_ok` pulses once with `inst_rdata` 0xDEAD_BEEF; `data_*_ok` stays 0; `owner` 01 then 00.
- Both request in the same IDLE cycle (fixed priority) → `owner` = 10, `mem_addr` = `data_addr`. After D-cache `data_ok`, the inst request is granted at K+1 with `mem_req` at K+2.
- Same as the previous scenario with `ARB_ROUND_ROBIN_EN` and both requesting continuously → grants alternate data, inst, data, inst over four transactions.
- D-cache write-back then refill (`wr`=1, `wen` 1111, addr 0x0000_0100, then `wr`=0 addr 0x0000_0200) while the I-cache also requests → two back-to-back data transactions; the inst request is not granted between them.
- Coincident `mem_addr_ok` & `mem_data_ok` in ADDR → one `data_ok` pulse to the owner; state IDLE on the next cycle.
- `rst` pulsed during DATA → `mem_req`/`owner`/`*_ok` are 0 within the same cycle. A `mem_data_ok` one cycle after release produces no master `data_ok`.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Two-master (I-cache, D-cache) to one SRAM-like memory port arbiter; one transaction in flight.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on ties instead of fixed data-over-inst priority.
module cache_mem_arbiter #(
  parameter int unsigned A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               inst_req,
  input  logic               inst_wr,
  input  logic [3:0]         inst_wen,
  input  logic [1:0]         inst_size,
  input  logic [A_WIDTH-1:0] inst_addr,
  input  logic [31:0]        inst_wdata,
  output logic [31:0]        inst_rdata,
  output logic               inst_addr_ok,
  output logic               inst_data_ok,

  input  logic               data_req,
  input  logic               data_wr,
  input  logic [3:0]         data_wen,
  input  logic [1:0]         data_size,
  input  logic [A_WIDTH-1:0] data_addr,
  input  logic [31:0]        data_wdata,
  output logic [31:0]        data_rdata,
  output logic               data_addr_ok,
  output logic               data_data_ok,

  output logic               mem_req,
  output logic               mem_wr,
  output logic [3:0]         mem_wen,
  output logic [1:0]         mem_size,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_addr_ok,
  input  logic               mem_data_ok,

  output logic [1:0]         owner
);

  localparam int unsigned D_WIDTH = 32;
  localparam int unsigned O_WIDTH = 2;

  localparam logic [O_WIDTH-1:0] OWN_NONE = 2'b00;
  localparam logic [O_WIDTH-1:0] OWN_INST = 2'b01;
  localparam logic [O_WIDTH-1:0] OWN_DATA = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic               wr;
    logic [3:0]         wen;
    logic [1:0]         size;
    logic [A_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] wdata;
  } req_fields_t;

  state_t               state_q, state_d;
  logic [O_WIDTH-1:0]   owner_q, owner_d;

  req_fields_t          inst_fields;
  req_fields_t          data_fields;
  req_fields_t          sel_fields;
  logic                 sel_req;
  logic                 grant_data;
  logic                 fwd_data_ok;

  assign inst_fields = '{wr: inst_wr, wen: inst_wen, size: inst_size,
                         addr: inst_addr, wdata: inst_wdata};
  assign data_fields = '{wr: data_wr, wen: data_wen, size: data_size,
                         addr: data_addr, wdata: data_wdata};

  // Owner's live request; only meaningful while a grant is held.
  assign sel_req    = owner_q[1] ? data_req    : inst_req;
  assign sel_fields = owner_q[1] ? data_fields : inst_fields;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant_q: 1 = data was granted last, 0 = inst (reset value).
  logic last_grant_q, last_grant_d;

  assign grant_data = data_req & (~inst_req | ~last_grant_q);

  always_ff @(posedge clk or posedge rst) begin : last_grant_reg
    if (rst) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign grant_data = data_req;
`endif

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    owner_d = owner_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (inst_req | data_req) begin
          state_d = S_ADDR;
          owner_d = grant_data ? OWN_DATA : OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = grant_data;
`endif
        end
      end
      S_ADDR: begin
        if (mem_addr_ok && mem_data_ok) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end else if (mem_addr_ok) begin
          state_d = S_DATA;
        end else if (!sel_req) begin
          // Owner gave up before the slave accepted; nothing was committed.
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end
      S_DATA: begin
        if (mem_data_ok) begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // data_ok belongs to the owner in DATA, or in ADDR when it coincides with addr_ok.
  assign fwd_data_ok = mem_data_ok &
                       ((state_q == S_DATA) | ((state_q == S_ADDR) & mem_addr_ok));

  always_comb begin : port_mux
    mem_req      = 1'b0;
    {mem_wr, mem_wen, mem_size, mem_addr, mem_wdata} = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    if (state_q == S_ADDR) begin
      mem_req      = sel_req;
      {mem_wr, mem_wen, mem_size, mem_addr, mem_wdata} = sel_fields;
      inst_addr_ok = owner_q[0] & mem_addr_ok;
      data_addr_ok = owner_q[1] & mem_addr_ok;
    end
    inst_data_ok = owner_q[0] & fwd_data_ok;
    data_data_ok = owner_q[1] & fwd_data_ok;
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign owner      = owner_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios with literal expectations plus
// randomized masters/slave compared every cycle against a transaction-level model.
module tb_cache_mem_arbiter;

  localparam int unsigned AW = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_wr;
  logic [3:0]    inst_wen;
  logic [1:0]    inst_size;
  logic [AW-1:0] inst_addr;
  logic [31:0]   inst_wdata, inst_rdata;
  logic          inst_addr_ok, inst_data_ok;
  logic          data_req, data_wr;
  logic [3:0]    data_wen;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [31:0]   data_wdata, data_rdata;
  logic          data_addr_ok, data_data_ok;
  logic          mem_req, mem_wr;
  logic [3:0]    mem_wen;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_addr_ok, mem_data_ok;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.A_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wen(inst_wen), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .owner(owner)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: is a grant held, by whom, and has the slave taken the address yet.
  bit m_busy, m_who, m_acc, m_last;   // m_who / m_last: 1 = data, 0 = inst
  bit e_iaok, e_daok;
  bit i_pend, d_pend;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_busy = 1'b0; m_who = 1'b0; m_acc = 1'b0; m_last = 1'b0;
  endtask

  function automatic bit pick(input bit ir, input bit dr);
    if (ir && dr) return RR_EN ? !m_last : 1'b1;
    return dr;
  endfunction

  task automatic zero_inputs();
    inst_req = 0; inst_wr = 0; inst_wen = '0; inst_size = '0; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_wen = '0; data_size = '0; data_addr = '0; data_wdata = '0;
    mem_rdata = '0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  // Compare every DUT output against what the model says this cycle must look like.
  task automatic check_model();
    bit aphase, oreq, fwd;
    logic [70:0] exp_f, act_f;
    #1;
    aphase = m_busy && !m_acc;
    oreq   = m_who ? data_req : inst_req;
    e_iaok = aphase && !m_who && mem_addr_ok;
    e_daok = aphase &&  m_who && mem_addr_ok;
    fwd    = m_busy && mem_data_ok && (m_acc || mem_addr_ok);
    if (!aphase)    exp_f = '0;
    else if (m_who) exp_f = {data_wr, data_wen, data_size, data_addr, data_wdata};
    else            exp_f = {inst_wr, inst_wen, inst_size, inst_addr, inst_wdata};
    act_f = {mem_wr, mem_wen, mem_size, mem_addr, mem_wdata};
    chk("owner", 128'(owner), 128'(m_busy ? (m_who ? 2'b10 : 2'b01) : 2'b00));
    chk("mem_req", 128'(mem_req), 128'(aphase && oreq));
    chk("mem_fields", 128'(act_f), 128'(exp_f));
    chk("addr_ok", 128'({inst_addr_ok, data_addr_ok}), 128'({e_iaok, e_daok}));
    chk("data_ok", 128'({inst_data_ok, data_data_ok}), 128'({fwd && !m_who, fwd && m_who}));
    chk("rdata", 128'({inst_rdata, data_rdata}), 128'({mem_rdata, mem_rdata}));
  endtask

  // Apply the transaction rules to this cycle's inputs, then move to the next cycle.
  task automatic advance();
    bit w, oreq;
    oreq = m_who ? data_req : inst_req;
    if (rst) mdl_reset();
    else if (!m_busy) begin
      if (inst_req || data_req) begin
        w = pick(inst_req, data_req);
        m_busy = 1'b1; m_who = w; m_acc = 1'b0; m_last = w;
      end
    end else if (!m_acc) begin
      if (mem_addr_ok && mem_data_ok) m_busy = 1'b0;
      else if (mem_addr_ok)           m_acc  = 1'b1;
      else if (!oreq)                 m_busy = 1'b0;
    end else if (mem_data_ok) m_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_drive();
    bit aphase, oreq;
    if (!i_pend) begin
      if ($urandom_range(0, 3) == 0) begin
        i_pend = 1'b1;
        inst_wr = 1'($urandom_range(0, 1)); inst_wen = 4'($urandom); inst_size = 2'($urandom);
        inst_addr = $urandom; inst_wdata = $urandom;
      end
    end else if ($urandom_range(0, 19) == 0) i_pend = 1'b0;
    if (!d_pend) begin
      if ($urandom_range(0, 2) == 0) begin
        d_pend = 1'b1;
        data_wr = 1'($urandom_range(0, 1)); data_wen = 4'($urandom); data_size = 2'($urandom);
        data_addr = $urandom; data_wdata = $urandom;
      end
    end else if ($urandom_range(0, 19) == 0) d_pend = 1'b0;
    inst_req = i_pend;
    data_req = d_pend;
    aphase = m_busy && !m_acc;
    oreq   = m_who ? data_req : inst_req;
    mem_rdata = $urandom;
    if (aphase && oreq) begin
      mem_addr_ok = ($urandom_range(0, 2) == 0);
      mem_data_ok = mem_addr_ok && ($urandom_range(0, 3) == 0);
    end else if (m_busy && m_acc) begin
      mem_addr_ok = 1'b0;
      mem_data_ok = ($urandom_range(0, 2) == 0);
    end else begin
      mem_addr_ok = 1'b0;
      mem_data_ok = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    zero_inputs();
    mdl_reset();
    i_pend = 0; d_pend = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_owner", 128'(owner), 128'(2'b00));
    chk("rst_mem_req", 128'(mem_req), 128'(1'b0));
    chk("rst_oks", 128'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 128'(4'b0));
    @(negedge clk);
    check_model();
    advance();
    rst = 1'b0;
    check_model();
    advance();

    // Lone I-cache read: addr_ok at +2, data_ok at +4.
    inst_req = 1; inst_addr = 32'h1FC0_0000;
    check_model(); chk("t1_idle_req", 128'(mem_req), 128'(1'b0)); advance();
    check_model();
    chk("t1_owner", 128'(owner), 128'(2'b01));
    chk("t1_mem_req", 128'(mem_req), 128'(1'b1));
    chk("t1_mem_addr", 128'(mem_addr), 128'(32'h1FC0_0000));
    advance();
    mem_addr_ok = 1;
    check_model(); chk("t1_addr_ok", 128'({inst_addr_ok, data_addr_ok}), 128'(2'b10)); advance();
    inst_req = 0; mem_addr_ok = 0;
    check_model(); chk("t1_owner_data", 128'(owner), 128'(2'b01)); advance();
    mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
    check_model();
    chk("t1_data_ok", 128'({inst_data_ok, data_data_ok}), 128'(2'b10));
    chk("t1_rdata", 128'(inst_rdata), 128'(32'hDEAD_BEEF));
    advance();
    mem_data_ok = 0;
    check_model();
    chk("t1_owner_idle", 128'(owner), 128'(2'b00));
    chk("t1_no_ok", 128'({inst_data_ok, data_data_ok}), 128'(2'b00));
    advance();

    // Simultaneous requests: data first, inst granted right after; inst ends coincidentally.
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_addr = 32'h0000_2000;
    check_model(); advance();
    mem_addr_ok = 1;
    check_model();
    chk("t2_owner", 128'(owner), 128'(2'b10));
    chk("t2_mem_addr", 128'(mem_addr), 128'(32'h0000_2000));
    chk("t2_addr_ok", 128'({inst_addr_ok, data_addr_ok}), 128'(2'b01));
    advance();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    check_model(); chk("t2_data_ok", 128'({inst_data_ok, data_data_ok}), 128'(2'b01)); advance();
    mem_data_ok = 0;
    check_model();
    chk("t2_k1_owner", 128'(owner), 128'(2'b00));
    chk("t2_k1_mem_req", 128'(mem_req), 128'(1'b0));
    advance();
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    check_model();
    chk("t2_k2_owner", 128'(owner), 128'(2'b01));
    chk("t2_k2_req", 128'({mem_req, mem_addr}), 128'({1'b1, 32'h0000_1000}));
    chk("t2_coinc_ok", 128'({inst_addr_ok, inst_data_ok, data_data_ok}), 128'(3'b110));
    advance();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    check_model();
    chk("t2_after_coinc", 128'({owner, inst_data_ok}), 128'(3'b000));
    advance();

    // D-cache write-back then refill with the I-cache also waiting.
    data_req = 1; data_wr = 1; data_wen = 4'hF; data_size = 2'd2;
    data_addr = 32'h0000_0100; data_wdata = 32'hCAFE_0001;
    inst_req = 1; inst_addr = 32'h0000_3000;
    check_model(); advance();
    mem_addr_ok = 1;
    check_model();
    chk("t3_wb_owner", 128'(owner), 128'(2'b10));
    chk("t3_wb_fields", 128'({mem_wr, mem_wen, mem_addr}), 128'({1'b1, 4'hF, 32'h0000_0100}));
    advance();
    data_req = 0; mem_addr_ok = 0;
    check_model(); advance();
    data_req = 1; data_wr = 0; data_wen = 4'h0; data_addr = 32'h0000_0200;
    mem_data_ok = 1;
    check_model(); chk("t3_wb_done", 128'(data_data_ok), 128'(1'b1)); advance();
    mem_data_ok = 0;
    check_model(); advance();
    mem_addr_ok = 1;
    check_model();
    chk("t3_refill_owner", 128'(owner), 128'(RR_EN ? 2'b01 : 2'b10));
    chk("t3_refill_addr", 128'(mem_addr), 128'(RR_EN ? 32'h0000_3000 : 32'h0000_0200));
    advance();

    // Reset pulsed in the data phase, then a stale data_ok after release.
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    check_model();
    chk("t4_in_data", 128'(owner == 2'b00), 128'(1'b0));
    #2;
    rst = 1; mem_data_ok = 1;
    mdl_reset();
    #1;
    chk("t4_rst_owner", 128'(owner), 128'(2'b00));
    chk("t4_rst_mem_req", 128'(mem_req), 128'(1'b0));
    chk("t4_rst_oks", 128'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 128'(4'b0));
    advance();
    rst = 0;
    check_model(); advance();
    check_model();
    chk("t4_stale_ok", 128'({inst_data_ok, data_data_ok, owner}), 128'(4'b0));
    advance();
    mem_data_ok = 0;

    // Randomized traffic against the model.
    zero_inputs();
    repeat (4000) begin
      rand_drive();
      check_model();
      if (e_iaok) i_pend = 1'b0;
      if (e_daok) d_pend = 1'b0;
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
